// File: rtl/jtframe_kabuki_enc_pkg.sv
// Shared Kabuki definitions: key layout, data-cycle address XOR and the
// self-inverse pair-swap functions used by both the encryptor and decryptor.
package jtframe_kabuki_enc_pkg;

    localparam int          KEY_BYTES      = 11;
    localparam logic [15:0] KABUKI_DATA_XA = 16'h1fc0;

    // First key byte loaded lands in swap_key1[31:24]
    typedef struct packed {
        logic [31:0] swap_key1;
        logic [31:0] swap_key2;
        logic [15:0] addr_key;
        logic [7:0]  xor_key;
    } kabuki_key_t;

    function automatic logic [7:0] rotr(input logic [7:0] d);
        return {d[0], d[7:1]};
    endfunction

    function automatic logic [7:0] bitswap1(input logic [7:0] d, input logic [15:0] key,
                                            input logic [7:0] sel);
        logic [7:0] o;
        logic       unused_key;
        unused_key = ^{key[15], key[11], key[7], key[3]};
        o = d;
        if (sel[key[2:0]])   o[1:0] = {d[0], d[1]};
        if (sel[key[6:4]])   o[3:2] = {d[2], d[3]};
        if (sel[key[10:8]])  o[5:4] = {d[4], d[5]};
        if (sel[key[14:12]]) o[7:6] = {d[6], d[7]};
        return o;
    endfunction

    // Same swaps as bitswap1 with the key nibbles taken in reverse order
    function automatic logic [7:0] bitswap2(input logic [7:0] d, input logic [15:0] key,
                                            input logic [7:0] sel);
        logic [7:0] o;
        logic       unused_key;
        unused_key = ^{key[15], key[11], key[7], key[3]};
        o = d;
        if (sel[key[14:12]]) o[1:0] = {d[0], d[1]};
        if (sel[key[10:8]])  o[3:2] = {d[2], d[3]};
        if (sel[key[6:4]])   o[5:4] = {d[4], d[5]};
        if (sel[key[2:0]])   o[7:6] = {d[6], d[7]};
        return o;
    endfunction

endpackage

// File: rtl/jtframe_kabuki_keys.sv
// Kabuki key loader: shifts one byte per falling edge of prog_we into the
// 88-bit key register and flags when all 11 bytes have arrived.
module jtframe_kabuki_keys
    import jtframe_kabuki_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  prog_data,
    input  logic        prog_we,
    output logic [87:0] keys,
    output logic        key_ok
);

    logic       last_we;
    logic [3:0] key_cnt;
    logic       strobe;

    assign strobe = last_we && !prog_we;
    assign key_ok = (key_cnt == 4'(KEY_BYTES));

    always_ff @(posedge clk) begin
        if (rst) begin
            keys    <= '0;
            key_cnt <= '0;
            last_we <= 1'b0;
        end else begin
            last_we <= prog_we;
            if (strobe) begin
                keys <= {keys[79:0], prog_data};
                // A byte after a complete key starts a fresh load
                key_cnt <= key_ok ? 4'd1 : key_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/jtframe_kabuki_enc.sv
// Kabuki Z80 ROM encryptor: two-stage stream that produces the byte the
// CPS 1.5 decryptor maps back to the plaintext at the given address/cycle.
module jtframe_kabuki_enc
    import jtframe_kabuki_enc_pkg::*;
#(
    parameter logic [15:0] DATA_XA = KABUKI_DATA_XA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  prog_data,
    input  logic        prog_we,
    output logic        key_ok,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_addr,
    input  logic        in_op,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_addr,
    output logic [7:0]  out_data
);

    logic [87:0] key_bits;
    kabuki_key_t key;

    jtframe_kabuki_keys u_keys (
        .clk       (clk),
        .rst       (rst),
        .prog_data (prog_data),
        .prog_we   (prog_we),
        .keys      (key_bits),
        .key_ok    (key_ok)
    );

    assign key = key_bits;

    logic        vld_p1;
    logic [15:0] addr_p1;
    logic [15:0] hit_p1;
    logic [7:0]  data_p1;
    logic        s2_free;
    logic        accept;
    logic [15:0] hit_in;
    logic [7:0]  enc_p1;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = key_ok && (!vld_p1 || s2_free);
    assign accept   = in_valid && in_ready;
    assign hit_in   = in_op ? in_addr + key.addr_key
                            : (in_addr ^ DATA_XA) + key.addr_key + 16'd1;

    // ---- stage 1: accept and compute the swap select ----
    always_ff @(posedge clk) begin
        if (rst)          vld_p1 <= 1'b0;
        else if (accept)  vld_p1 <= 1'b1;
        else if (s2_free) vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1 <= in_addr;
            data_p1 <= in_data;
            hit_p1  <= hit_in;
        end
    end

    // ---- stage 2: decryptor steps undone in reverse order ----
    always_comb begin
        enc_p1 = data_p1;
        enc_p1 = bitswap1(enc_p1, key.swap_key2[31:16], hit_p1[15:8]);
        enc_p1 = rotr(enc_p1);
        enc_p1 = bitswap2(enc_p1, key.swap_key2[15:0], hit_p1[15:8]);
        enc_p1 = rotr(enc_p1);
        enc_p1 = enc_p1 ^ key.xor_key;
        enc_p1 = bitswap2(enc_p1, key.swap_key1[31:16], hit_p1[7:0]);
        enc_p1 = rotr(enc_p1);
        enc_p1 = bitswap1(enc_p1, key.swap_key1[15:0], hit_p1[7:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (s2_free) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_addr <= addr_p1;
                out_data <= enc_p1;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_kabuki_enc.sv
// Bench for the Kabuki encryptor: a decryptor model inverted by search
// provides every expected ciphertext byte.
module tb_jtframe_kabuki_enc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  prog_data = '0;
    logic        prog_we = 1'b0;
    logic        key_ok;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_addr = '0;
    logic        in_op = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_addr;
    logic [7:0]  out_data;

    int vectors = 0;
    int miscompares = 0;
    logic [87:0] cur_key = '0;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        o;
    } vec_t;

    always #5 clk = ~clk;

    jtframe_kabuki_enc dut (
        .clk       (clk),
        .rst       (rst),
        .prog_data (prog_data),
        .prog_we   (prog_we),
        .key_ok    (key_ok),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data)
    );

    // Decryptor reference, written as the classic software routine
    function automatic int unsigned m_swap(int unsigned s, int unsigned key, int unsigned sel,
                                           int unsigned k0, int unsigned k1,
                                           int unsigned k2, int unsigned k3);
        if (((sel >> ((key >> k0) & 7)) & 1) != 0) s = (s & 'hfc) | ((s & 1) << 1) | ((s & 2) >> 1);
        if (((sel >> ((key >> k1) & 7)) & 1) != 0) s = (s & 'hf3) | ((s & 4) << 1) | ((s & 8) >> 1);
        if (((sel >> ((key >> k2) & 7)) & 1) != 0) s = (s & 'hcf) | ((s & 16) << 1) | ((s & 32) >> 1);
        if (((sel >> ((key >> k3) & 7)) & 1) != 0) s = (s & 'h3f) | ((s & 64) << 1) | ((s & 128) >> 1);
        return s;
    endfunction

    function automatic int unsigned m_rotl(int unsigned s);
        return ((s & 'h7f) << 1) | ((s & 'h80) >> 7);
    endfunction

    function automatic int unsigned m_dec(int unsigned src, int unsigned addr, bit op, logic [87:0] k);
        int unsigned sk1, sk2, ak, xk, sel, lo, hi;
        sk1 = k[87:56]; sk2 = k[55:24]; ak = k[23:8]; xk = k[7:0];
        sel = op ? ((addr + ak) & 'hffff) : (((addr ^ 'h1fc0) + ak + 1) & 'hffff);
        lo = sel & 'hff;
        hi = sel >> 8;
        src = m_swap(src, sk1 & 'hffff, lo, 0, 4, 8, 12);
        src = m_rotl(src);
        src = m_swap(src, sk1 >> 16, lo, 12, 8, 4, 0);
        src = src ^ xk;
        src = m_rotl(src);
        src = m_swap(src, sk2 & 'hffff, hi, 12, 8, 4, 0);
        src = m_rotl(src);
        src = m_swap(src, sk2 >> 16, hi, 0, 4, 8, 12);
        return src;
    endfunction

    // The ciphertext is the unique byte the decryptor maps to the plaintext
    function automatic logic [7:0] m_enc(logic [15:0] addr, logic [7:0] plain, bit op);
        for (int c = 0; c < 256; c++)
            if (m_dec(c, addr, op, cur_key) == plain) return 8'(c);
        return 8'hxx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        prog_data = b;
        prog_we = 1'b1;
        @(posedge clk); #1;
        prog_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_key(input logic [87:0] kv, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(kv[87 - 8*i -: 8]);
        if (nbytes == 11) cur_key = kv;
    endtask

    function automatic logic [87:0] rand_key();
        return {$urandom(), $urandom(), 24'($urandom())};
    endfunction

    function automatic vec_t pick(int idx);
        logic [15:0] dir [8] = '{16'h0000, 16'hffff, 16'h1fc0, 16'he03f,
                                 16'h0001, 16'h8000, 16'h7fff, 16'h1fbf};
        vec_t v;
        v.d = 8'($urandom_range(255));
        if (idx < 16) begin
            v.a = dir[idx / 2];
            v.o = idx[0];
        end else begin
            v.a = 16'($urandom());
            v.o = 1'($urandom_range(1));
        end
        return v;
    endfunction

    task automatic run_stream(input int n, input int rdy_pct);
        vec_t q[$];
        vec_t cur, ev;
        int sent, recvd, cyc;
        logic hold, take;
        logic [7:0] held_d;
        sent = 0; recvd = 0; cyc = 0; hold = 1'b0; held_d = '0;
        cur = pick(0);
        while (recvd < n && cyc < 8*n + 200) begin
            in_valid  = (sent < n);
            in_addr   = cur.a;
            in_data   = cur.d;
            in_op     = cur.o;
            out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (hold) check("stall_hold", 32'(out_data), 32'(held_d));
            take = in_valid && in_ready;
            if (take) begin
                q.push_back(cur);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_spurious", 32'(q.size()), 32'd1);
                end else begin
                    ev = q.pop_front();
                    check("stream_data", 32'(out_data), 32'(m_enc(ev.a, ev.d, ev.o)));
                    check("stream_addr", 32'(out_addr), 32'(ev.a));
                    recvd++;
                end
            end
            hold   = out_valid && !out_ready;
            held_d = out_data;
            @(posedge clk); #1;
            cyc++;
            if (take) cur = pick(sent);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(recvd), 32'(n));
    endtask

    initial begin
        logic [87:0] ka;
        logic [7:0] ea;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_key_ok", 32'(key_ok), 32'd0);

        // all-zero keys: plain rotate-right by three, two clocks after accept
        load_key(88'h0, 11);
        check("zero_key_ok", 32'(key_ok), 32'd1);
        in_valid = 1'b1; in_op = 1'b1; in_addr = 16'h0000; in_data = 8'h01;
        @(negedge clk);
        check("lat_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("zero_key_data", 32'(out_data), 32'h20);
        check("zero_key_model", 32'(out_data), 32'(m_enc(16'h0000, 8'h01, 1'b1)));

        // a new byte after a full key restarts the load
        send_byte(8'h00);
        check("reload_key_ok", 32'(key_ok), 32'd0);
        load_key(88'h0000000000000000000000, 9);
        send_byte(8'hff);
        cur_key = 88'hff;
        check("xor_key_ok", 32'(key_ok), 32'd1);
        in_valid = 1'b1; in_op = 1'b1; in_addr = 16'h0000; in_data = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("xor_valid", 32'(out_valid), 32'd1);
        check("xor_data", 32'(out_data), 32'hdf);

        // random key, round trip at full rate and under random backpressure
        ka = rand_key();
        load_key(ka, 11);
        run_stream(1500, 100);
        run_stream(1500, 60);

        // output held for 5 clocks with two bytes in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 1'b1; in_addr = 16'h1234; in_data = 8'h5a;
        @(negedge clk);
        check("stall_acc1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_op = 1'b0; in_addr = 16'h1235; in_data = 8'ha5;
        @(negedge clk);
        check("stall_acc2", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_op = 1'b1; in_addr = 16'h1236; in_data = 8'h3c;
        ea = m_enc(16'h1234, 8'h5a, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_full", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(ea));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_acc3", 32'(in_ready), 32'd1);
        check("drain_a", 32'(out_data), 32'(ea));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_b_v", 32'(out_valid), 32'd1);
        check("drain_b", 32'(out_data), 32'(m_enc(16'h1235, 8'ha5, 1'b0)));
        check("drain_b_addr", 32'(out_addr), 32'h1235);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_c", 32'(out_data), 32'(m_enc(16'h1236, 8'h3c, 1'b1)));
        check("drain_c_addr", 32'(out_addr), 32'h1236);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_empty", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // partial key keeps the stream closed until the 11th byte
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ka = rand_key();
        load_key(ka, 10);
        check("part_key_ok", 32'(key_ok), 32'd0);
        check("part_in_ready", 32'(in_ready), 32'd0);
        send_byte(ka[7:0]);
        cur_key = ka;
        check("full_key_ok", 32'(key_ok), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd1);

        // reset with two bytes in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 1'b0; in_addr = 16'h4000; in_data = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("inflight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_key_ok", 32'(key_ok), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        ka = rand_key();
        load_key(ka, 11);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_stream(1000, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
